ddr2_cmd_arbiter: RTL and testbench

Owns the DDR2 command bus (CKE, CS/RAS/CAS/WE, BA, ADDR) after reset. It passes through the power-up init sequencer until init_end, then shares the bus between three requesters: auto-refresh, write and read.
- Contains the tREFI refresh-interval timer.
- Enforces refresh priority.
- Alternates write/read grants round-robin.
- Sits between the init/refresh/write/read command generators and the DDR2 PHY pads.

---
 rtl/ddr2_cmd_arbiter_pkg.sv | 29 ++
 rtl/ddr2_ref_timer.sv | 51 +++++
 rtl/ddr2_cmd_arbiter.sv | 149 ++++++++++++++
 tb/tb_ddr2_cmd_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared DDR2 command encodings ({cs_n,ras_n,cas_n,we_n}), arbiter state and refresh-interval constants.
package ddr2_cmd_arbiter_pkg;

  localparam logic [3:0] CMD_LM   = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  localparam int TREFI_NS      = 7800;
  localparam int TCK_NS        = 5;
  localparam int TREFI_CYC_DEF = TREFI_NS / TCK_NS;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_AREF,
    ST_WR,
    ST_RD
  } state_e;

  typedef enum logic {
    RR_WR,
    RR_RD
  } rr_e;

endpackage

// File: rtl/ddr2_ref_timer.sv
// tREFI interval timer plus saturating count of refreshes still owed; both update one clock after their cause.
module ddr2_ref_timer #(
  parameter int TREFI_CYC    = 1560,
  parameter int REF_PEND_MAX = 8
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       run_i,
  input  logic       aref_end_i,
  output logic       aref_req_o,
  output logic [3:0] ref_pend_o
);

  localparam int TW = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pend_q, pend_d;
  logic          tick;

  always_comb begin
    tick    = run_i && (timer_q == TW'(TREFI_CYC - 1));
    timer_d = timer_q + 1'b1;
    if (!run_i || tick) begin
      timer_d = '0;
    end

    // A tick and a completed refresh cancel each other out.
    pend_d = pend_q;
    if (tick && !aref_end_i) begin
      if (pend_q < 4'(REF_PEND_MAX)) begin
        pend_d = pend_q + 4'd1;
      end
    end else if (!tick && aref_end_i && (pend_q != 4'd0)) begin
      pend_d = pend_q - 4'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      timer_q <= '0;
      pend_q  <= 4'd0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign aref_req_o = (pend_q != 4'd0);
  assign ref_pend_o = pend_q;

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// DDR2 command-bus owner: init pass-through, then refresh-first / write-read round-robin arbitration.
// All pad outputs are registered (one clock latency); an active owner is never pre-empted.
module ddr2_cmd_arbiter
  import ddr2_cmd_arbiter_pkg::*;
#(
  parameter int BA_BITS      = 3,
  parameter int ADDR_BITS    = 13,
  parameter int TREFI_CYC    = TREFI_CYC_DEF,
  parameter int REF_PEND_MAX = 8
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 init_cke,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 init_end,
  output logic                 aref_en,
  input  logic                 aref_end,
  input  logic [3:0]           aref_cmd,
  input  logic [BA_BITS-1:0]   aref_ba,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 wr_req,
  output logic                 wr_en,
  input  logic                 wr_end,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 rd_req,
  output logic                 rd_en,
  input  logic                 rd_end,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 ddr_cke,
  output logic [3:0]           ddr_cmd,
  output logic [BA_BITS-1:0]   ddr_ba,
  output logic [ADDR_BITS-1:0] ddr_addr,
  output logic [3:0]           ref_pend
);

  state_e                 state_q;
  rr_e                    rr_q;
  logic                   aref_en_q, wr_en_q, rd_en_q;
  logic                   cke_q, cke_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [BA_BITS-1:0]     ba_q, ba_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   aref_req;
  logic                   grant_wr, grant_rd;

  ddr2_ref_timer #(
    .TREFI_CYC    (TREFI_CYC),
    .REF_PEND_MAX (REF_PEND_MAX)
  ) u_timer (
    .ck         (ck),
    .rst        (rst),
    .run_i      (state_q != ST_INIT),
    .aref_end_i (aref_end),
    .aref_req_o (aref_req),
    .ref_pend_o (ref_pend)
  );

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_wr = wr_req && (!rd_req || (rr_q == RR_WR));
    grant_rd = rd_req && (!wr_req || (rr_q == RR_RD));
  end

  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    ba_d   = ba_q;
    addr_d = addr_q;
    case (state_q)
      ST_INIT: begin
        cke_d  = init_cke;
        cmd_d  = init_cmd;
        ba_d   = init_ba;
        addr_d = init_addr;
      end
      ST_AREF: begin
        cmd_d  = aref_cmd;
        ba_d   = aref_ba;
        addr_d = aref_addr;
      end
      ST_WR: begin
        cmd_d  = wr_cmd;
        ba_d   = wr_ba;
        addr_d = wr_addr;
      end
      ST_RD: begin
        cmd_d  = rd_cmd;
        ba_d   = rd_ba;
        addr_d = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= ST_INIT;
      rr_q      <= RR_WR;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
    end else begin
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      case (state_q)
        ST_INIT: if (init_end) state_q <= ST_ARB;
        ST_ARB: begin
          if (aref_req) begin
            state_q   <= ST_AREF;
            aref_en_q <= 1'b1;
          end else if (grant_wr || grant_rd) begin
            state_q <= grant_wr ? ST_WR : ST_RD;
            wr_en_q <= grant_wr;
            rd_en_q <= grant_rd;
            rr_q    <= (rr_q == RR_WR) ? RR_RD : RR_WR;
          end
        end
        ST_AREF: if (aref_end) state_q <= ST_ARB;
        ST_WR:   if (wr_end)   state_q <= ST_ARB;
        ST_RD:   if (rd_end)   state_q <= ST_ARB;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign aref_en  = aref_en_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign ddr_cke  = cke_q;
  assign ddr_cmd  = cmd_q;
  assign ddr_ba   = ba_q;
  assign ddr_addr = addr_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed bench for ddr2_cmd_arbiter: init mirror, refresh timing/saturation, round-robin, reset abort.
module tb_ddr2_cmd_arbiter;
  import ddr2_cmd_arbiter_pkg::*;

  localparam int BA    = 3;
  localparam int AD    = 13;
  localparam int TREFI = 1560;
  localparam int PMAX  = 8;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          init_cke = 1'b0, init_end = 1'b0;
  logic [3:0]    init_cmd = 4'b0000;
  logic [BA-1:0] init_ba = '0;
  logic [AD-1:0] init_addr = '0;
  logic          aref_en, aref_end = 1'b0;
  logic [3:0]    aref_cmd = CMD_NOP;
  logic [BA-1:0] aref_ba = '0;
  logic [AD-1:0] aref_addr = '0;
  logic          wr_req = 1'b0, wr_en, wr_end = 1'b0;
  logic [3:0]    wr_cmd = CMD_NOP;
  logic [BA-1:0] wr_ba = '0;
  logic [AD-1:0] wr_addr = '0;
  logic          rd_req = 1'b0, rd_en, rd_end = 1'b0;
  logic [3:0]    rd_cmd = CMD_NOP;
  logic [BA-1:0] rd_ba = '0;
  logic [AD-1:0] rd_addr = '0;
  logic          ddr_cke;
  logic [3:0]    ddr_cmd;
  logic [BA-1:0] ddr_ba;
  logic [AD-1:0] ddr_addr;
  logic [3:0]    ref_pend;

  ddr2_cmd_arbiter #(
    .BA_BITS(BA), .ADDR_BITS(AD), .TREFI_CYC(TREFI), .REF_PEND_MAX(PMAX)
  ) dut (
    .ck(ck), .rst(rst),
    .init_cke(init_cke), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .init_end(init_end),
    .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_addr(rd_addr),
    .ddr_cke(ddr_cke), .ddr_cmd(ddr_cmd), .ddr_ba(ddr_ba), .ddr_addr(ddr_addr),
    .ref_pend(ref_pend)
  );

  always #5 ck = ~ck;

  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int arb_cyc = 0;
  int exp_pend = 0;
  bit running = 1'b0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit tick_next();
    return running && (((cyc - arb_cyc) % TREFI) == TREFI - 1);
  endfunction

  // Advance one clock; keep the bench's own pending-refresh model in step.
  task automatic step();
    bit tk;
    tk = tick_next();
    if (rst) exp_pend = 0;
    else if (tk && aref_end) exp_pend = exp_pend;
    else if (tk) begin
      if (exp_pend < PMAX) exp_pend++;
    end else if (aref_end && exp_pend > 0) exp_pend--;
    @(posedge ck);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] en_vec();
    return 32'({aref_en, wr_en, rd_en});
  endfunction

  function automatic logic [31:0] bus_vec();
    return 32'({ddr_cmd, ddr_ba, ddr_addr});
  endfunction

  // One full ownership: grant from ARB, drive owner bus, check pad copy, end back to ARB.
  task automatic own_cycle(input int who, input logic [3:0] c, input logic [BA-1:0] b,
                           input logic [AD-1:0] a);
    logic [2:0] en_exp;
    en_exp = 3'b100 >> who;
    step();
    chk("grant", en_vec(), 32'(en_exp));
    case (who)
      0: begin aref_cmd = c; aref_ba = b; aref_addr = a; end
      1: begin wr_cmd = c; wr_ba = b; wr_addr = a; end
      default: begin rd_cmd = c; rd_ba = b; rd_addr = a; end
    endcase
    step();
    chk("grant_one_cycle", en_vec(), 32'd0);
    chk("owner_bus", bus_vec(), 32'({c, b, a}));
    case (who)
      0: aref_end = 1'b1;
      1: wr_end = 1'b1;
      default: rd_end = 1'b1;
    endcase
    step();
    aref_end = 1'b0;
    wr_end = 1'b0;
    rd_end = 1'b0;
    chk("back_to_arb", 32'(dut.state_q), 32'(ST_ARB));
  endtask

  initial begin
    logic [20:0] drv;
    logic [3:0]  maxp;
    int          n;

    // 1: reset and init pass-through
    step();
    step();
    chk("rst_pads", 32'({ddr_cke, ddr_cmd, ddr_ba, ddr_addr}), 32'({1'b0, CMD_NOP, 3'd0, 13'd0}));
    chk("rst_en", en_vec(), 32'd0);
    chk("rst_pend", 32'(ref_pend), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_INIT));
    rst = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      init_cke  = (i >= 50);
      init_cmd  = 4'(i);
      init_ba   = 3'(i);
      init_addr = 13'(i * 7);
      init_end  = (i == 100);
      drv = {init_cke, init_cmd, init_ba, init_addr};
      step();
      chk("init_mirror", 32'({ddr_cke, ddr_cmd, ddr_ba, ddr_addr}), 32'(drv));
      chk("init_no_en", en_vec(), 32'd0);
    end
    chk("init_to_arb", 32'(dut.state_q), 32'(ST_ARB));
    arb_cyc = cyc;
    running = 1'b1;
    init_end  = 1'b0;
    init_cke  = 1'b0;
    init_cmd  = CMD_LM;
    init_ba   = 3'd7;
    init_addr = 13'h1fff;
    step();
    chk("arb_pads", 32'({ddr_cke, ddr_cmd, ddr_ba, ddr_addr}), 32'({1'b1, CMD_NOP, 3'd4, 13'd700}));
    chk("arb_idle_en", en_vec(), 32'd0);

    // 2: first refresh interval
    while (cyc < arb_cyc + TREFI - 1) step();
    chk("pend_before_trefi", 32'(ref_pend), 32'd0);
    step();
    chk("pend_at_trefi", 32'(ref_pend), 32'd1);
    chk("no_grant_yet", en_vec(), 32'd0);
    step();
    chk("aref_grant", en_vec(), 32'b100);
    chk("state_aref", 32'(dut.state_q), 32'(ST_AREF));
    aref_cmd  = CMD_AREF;
    aref_ba   = 3'd5;
    aref_addr = 13'h0400;
    step();
    chk("aref_pulse_len", en_vec(), 32'd0);
    chk("aref_bus", bus_vec(), 32'({CMD_AREF, 3'd5, 13'h0400}));
    for (int i = 0; i < 18; i++) step();
    aref_end = 1'b1;
    aref_cmd = CMD_PRE;
    step();
    aref_end = 1'b0;
    chk("pend_after_aref", 32'(ref_pend), 32'd0);
    chk("aref_done_arb", 32'(dut.state_q), 32'(ST_ARB));
    step();
    chk("arb_nop_hold", bus_vec(), 32'({CMD_NOP, 3'd5, 13'h0400}));
    chk("arb_no_req", en_vec(), 32'd0);

    // 3: round-robin between write and read
    wr_req = 1'b1;
    rd_req = 1'b1;
    own_cycle(1, CMD_WR, 3'd1, 13'h0011);
    own_cycle(2, CMD_RD, 3'd2, 13'h0022);
    own_cycle(1, CMD_ACT, 3'd3, 13'h0033);
    own_cycle(2, CMD_RD, 3'd4, 13'h0044);
    wr_req = 1'b0;
    own_cycle(2, CMD_PRE, 3'd6, 13'h0066);

    // 4: long write saturates pending refreshes; refresh then beats the waiting read
    wr_req = 1'b1;
    rd_req = 1'b0;
    step();
    chk("wr_grant", en_vec(), 32'b010);
    wr_cmd  = CMD_WR;
    wr_ba   = 3'd6;
    wr_addr = 13'h1abc;
    maxp = 4'd0;
    for (int k = 0; k < 20000; k++) begin
      rd_end = (k == 100);
      step();
      if (ref_pend > maxp) maxp = ref_pend;
    end
    chk("wr_held", 32'(dut.state_q), 32'(ST_WR));
    chk("pend_saturated", 32'(ref_pend), 32'd8);
    chk("pend_max_seen", 32'(maxp), 32'd8);
    chk("wr_bus", bus_vec(), 32'({CMD_WR, 3'd6, 13'h1abc}));
    rd_req = 1'b1;
    wr_req = 1'b0;
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("wr_done_arb", 32'(dut.state_q), 32'(ST_ARB));
    n = 0;
    while (exp_pend != 3 && n < 20) begin
      own_cycle(0, CMD_AREF, 3'd7, 13'h0400);
      n++;
    end
    chk("pend_drained_to_3", 32'(ref_pend), 32'd3);

    // 5: tick coincides with aref_end
    step();
    chk("aref_grant_p3", en_vec(), 32'b100);
    n = 0;
    while (!tick_next() && n < 2000) begin
      step();
      n++;
    end
    ntot++;
    assert (n < 2000) npass++;
    else $error("FAIL tick_wait: got %0d cycles required below 2000", n);
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    chk("tick_and_end", 32'(ref_pend), 32'd3);
    chk("tick_end_arb", 32'(dut.state_q), 32'(ST_ARB));

    // 6: reset during a read
    n = 0;
    while (exp_pend != 0 && n < 20) begin
      own_cycle(0, CMD_AREF, 3'd7, 13'h0400);
      n++;
    end
    step();
    chk("rd_grant", en_vec(), 32'b001);
    rd_cmd  = CMD_RD;
    rd_ba   = 3'd2;
    rd_addr = 13'h0155;
    step();
    chk("rd_bus", bus_vec(), 32'({CMD_RD, 3'd2, 13'h0155}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    running = 1'b0;
    chk("rst_mid_state", 32'(dut.state_q), 32'(ST_INIT));
    chk("rst_mid_pads", 32'({ddr_cke, ddr_cmd, ddr_ba, ddr_addr}), 32'({1'b0, CMD_NOP, 3'd0, 13'd0}));
    chk("rst_mid_pend", 32'(ref_pend), 32'd0);
    chk("rst_mid_en", en_vec(), 32'd0);
    init_cke  = 1'b0;
    init_cmd  = CMD_PRE;
    init_ba   = 3'd0;
    init_addr = 13'h0400;
    rd_end    = 1'b1;
    step();
    rd_end = 1'b0;
    chk("late_rd_end_ignored", 32'(dut.state_q), 32'(ST_INIT));
    chk("late_rd_no_en", en_vec(), 32'd0);
    chk("reinit_mirror", 32'({ddr_cke, ddr_cmd, ddr_ba, ddr_addr}), 32'({1'b0, CMD_PRE, 3'd0, 13'h0400}));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
